// File: rtl/imem_loader_pkg.sv
// Shared types, constants and the rolling-checksum step for the instruction
// memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_RUN    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Cycles from a registered ren_ext to rdata_ext being valid.
  localparam int IMEM_RD_LAT = 1;

  localparam int CSUM_MAX_W = 64;
  typedef logic [CSUM_MAX_W-1:0] csum_word_t;

  // Rotate-left-by-one then XOR, over the low 'width' bits; callers pass
  // zero-extended operands and truncate the result back to their width.
  function automatic csum_word_t csum_step(input csum_word_t c,
                                           input csum_word_t w,
                                           input int unsigned width);
    csum_word_t mask;
    mask = (width >= CSUM_MAX_W) ? '1
         : ((csum_word_t'(1) << width) - csum_word_t'(1));
    return (((c << 1) | (c >> (width - 1))) & mask) ^ (w & mask);
  endfunction

endpackage

// File: rtl/imem_loader_csum_accum.sv
// Rolling checksum register: synchronous clear wins over enable.
module csum_accum
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] csum
);

  logic [DATA_W-1:0] csum_nxt;

  assign csum_nxt = DATA_W'(csum_step(csum_word_t'(csum), csum_word_t'(din), DATA_W));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      csum <= '0;
    end else if (clear) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum_nxt;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams an image into instruction memory, optionally reads
// it back against a rolling checksum, then enables the cpu until halted.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              halt,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] checksum,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam int              PAD_W   = 64 - ADDR_W - 2;

  state_t state_q, state_d;

  logic [ADDR_W:0]        len_q;
  logic [ADDR_W:0]        len_m1;
  logic [ADDR_W:0]        wr_cnt_q;
  logic [ADDR_W:0]        rd_cnt_q;
  logic [ADDR_W:0]        cap_cnt_q;
  logic [ADDR_W-1:0]      word_addr_q;
  logic [IMEM_RD_LAT-1:0] rd_pipe_q;
  logic [DATA_W-1:0]      ver_csum;

  logic       len_ok;
  logic       hs;
  logic       last_wr;
  logic       rd_issue;
  logic       cap;
  logic       last_cap;
  logic       csum_match;
  logic       start_load;
  logic       err_load;
  logic [1:0] err_val;

  // Stream handshake: a word transfers on every rising edge where s_valid and
  // s_ready are both high. s_ready depends only on state, never on s_valid,
  // and the source must hold s_data stable while s_valid is high.
  assign s_ready = (state_q == S_LOAD);
  assign hs      = s_valid && s_ready;

  assign len_ok   = (prog_len != '0) && (prog_len <= DEPTH);
  assign len_m1   = len_q - CNT_ONE;
  assign last_wr  = hs && (wr_cnt_q == len_m1);
  assign rd_issue = (state_q == S_VERIFY) && (rd_cnt_q != len_q);
  assign cap      = (state_q == S_VERIFY) && rd_pipe_q[IMEM_RD_LAT-1];
  assign last_cap = cap && (cap_cnt_q == len_m1);

  // The verify register lags the word being captured, so fold it in here.
  assign csum_match = (DATA_W'(csum_step(csum_word_t'(ver_csum),
                                         csum_word_t'(rdata_ext), DATA_W)) == checksum);

  assign addr_ext  = {{PAD_W{1'b0}}, word_addr_q, 2'b00};
  assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign error     = (state_q == S_ERR);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    err_load   = 1'b0;
    err_val    = ERR_NONE;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          if (len_ok) begin
            state_d    = S_LOAD;
            start_load = 1'b1;
          end else begin
            state_d  = S_ERR;
            err_load = 1'b1;
            err_val  = ERR_LEN;
          end
        end
      end
      S_LOAD: begin
        if (last_wr) begin
          state_d = (VERIFY != 0) ? S_VERIFY : S_RUN;
        end
      end
      S_VERIFY: begin
        if (last_cap) begin
          if (csum_match) begin
            state_d = S_RUN;
          end else begin
            state_d  = S_ERR;
            err_load = 1'b1;
            err_val  = ERR_CSUM;
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      word_addr_q <= '0;
      rd_pipe_q   <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      wdata_ext   <= '0;
      cpu_enable  <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      wen_ext    <= hs;
      ren_ext    <= rd_issue;
      rd_pipe_q  <= IMEM_RD_LAT'({rd_pipe_q, ren_ext});
      cpu_enable <= (state_q == S_RUN) && !halt;

      if (start_load) begin
        len_q     <= prog_len;
        wr_cnt_q  <= '0;
        rd_cnt_q  <= '0;
        cap_cnt_q <= '0;
      end else begin
        if (hs)       wr_cnt_q  <= wr_cnt_q + CNT_ONE;
        if (rd_issue) rd_cnt_q  <= rd_cnt_q + CNT_ONE;
        if (cap)      cap_cnt_q <= cap_cnt_q + CNT_ONE;
      end

      // Writes and reads live in different states, so they never collide.
      if (hs) begin
        word_addr_q <= wr_cnt_q[ADDR_W-1:0];
        wdata_ext   <= s_data;
      end else if (rd_issue) begin
        word_addr_q <= rd_cnt_q[ADDR_W-1:0];
      end

      if (start_load) begin
        err_code <= ERR_NONE;
      end else if (err_load) begin
        err_code <= err_val;
      end
    end
  end

  csum_accum #(.DATA_W(DATA_W)) u_load_csum (
    .clk    (clk),
    .arst_n (arst_n),
    .clear  (start_load),
    .en     (hs),
    .din    (s_data),
    .csum   (checksum)
  );

  csum_accum #(.DATA_W(DATA_W)) u_verify_csum (
    .clk    (clk),
    .arst_n (arst_n),
    .clear  (start_load),
    .en     (cap),
    .din    (rdata_ext),
    .csum   (ver_csum)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes/reads are queued by the
// drivers and popped by a monitor; state/status checks are done inline.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk      = 1'b0;
  logic              arst_n   = 1'b1;
  logic              start    = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              halt     = 1'b0;
  logic              s_valid  = 1'b0;
  logic [DATA_W-1:0] s_data   = '0;
  logic [DATA_W-1:0] rdata_ext = '0;
  logic              s_ready;
  logic [63:0]       addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic              cpu_enable;
  logic              busy;
  logic              error;
  logic [1:0]        err_code;
  logic [DATA_W-1:0] checksum;
  logic [2:0]        dbg_state;

  int tests = 0;
  int fails = 0;

  logic [95:0]       exp_q[$];
  logic [63:0]       exp_rd_q[$];
  logic [DATA_W-1:0] mem [0:511];
  logic              corrupt = 1'b0;
  logic [DATA_W-1:0] cur_prog [0:7];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VERIFY(1)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .prog_len   (prog_len),
    .halt       (halt),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .rdata_ext  (rdata_ext),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error),
    .err_code   (err_code),
    .checksum   (checksum),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (1-cycle read latency) ----------------
  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^ ((corrupt && addr_ext == 64'd8) ? 32'h1 : 32'h0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [95:0] e;
    if (wen_ext && ren_ext) check("wen_ren_overlap", 64'(ren_ext), 64'd0);
    if (wen_ext) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", addr_ext, e[95:32]);
        check("write_data", 64'(wdata_ext), 64'(e[31:0]));
      end
    end
    if (ren_ext) begin
      if (exp_rd_q.size() == 0) begin
        check("unexpected_read_addr", addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("read_addr", addr_ext, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    start = 1'b1;
    prog_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit throttle, input bit push_reads);
    int g;
    for (int i = 0; i < n; i++) begin
      if (throttle && i > 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = cur_prog[i];
      g = 0;
      while (!s_ready && g < 20) begin @(posedge clk); #1; g++; end
      if (!s_ready) begin
        check("s_ready_timeout", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        return;
      end
      exp_q.push_back({64'(4 * i), cur_prog[i]});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (push_reads) for (int i = 0; i < n; i++) exp_rd_q.push_back(64'(4 * i));
  endtask

  task automatic wait_run(input int exp_n, input string name);
    int n;
    n = 0;
    while (!cpu_enable && n < 100) begin @(posedge clk); #1; n++; end
    check(name, 64'(n), 64'(exp_n));
  endtask

  task automatic do_halt();
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    check("halt_cpu_enable", 64'(cpu_enable), 64'd0);
  endtask

  task automatic load_basic_prog();
    cur_prog[0] = 32'h0000_0013;
    cur_prog[1] = 32'h0010_0093;
    cur_prog[2] = 32'h0020_8113;
    cur_prog[3] = 32'h0000_006F;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit en_seen;

    // reset
    #2 arst_n = 1'b0;
    #10;
    check("rst_s_ready",    64'(s_ready), 64'd0);
    check("rst_wen",        64'(wen_ext), 64'd0);
    check("rst_ren",        64'(ren_ext), 64'd0);
    check("rst_addr",       addr_ext, 64'd0);
    check("rst_wdata",      64'(wdata_ext), 64'd0);
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_error",      64'(error), 64'd0);
    check("rst_err_code",   64'(err_code), 64'd0);
    check("rst_checksum",   64'(checksum), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    tick(2);

    // basic load of 4 words
    load_basic_prog();
    do_start(10'd4);
    check("basic_busy",    64'(busy), 64'd1);
    check("basic_s_ready", 64'(s_ready), 64'd1);
    stream(4, 1'b0, 1'b1);
    wait_run(7, "basic_run_latency");
    check("basic_checksum",   64'(checksum), 64'h0001_009D);
    check("basic_error",      64'(error), 64'd0);
    check("basic_busy_run",   64'(busy), 64'd0);
    check("basic_reads_done", 64'(exp_rd_q.size()), 64'd0);

    // halt together with start in RUN: halt wins
    halt = 1'b1; start = 1'b1; prog_len = 10'd4;
    @(posedge clk); #1;
    halt = 1'b0; start = 1'b0;
    check("halt_cpu_enable", 64'(cpu_enable), 64'd0);
    check("halt_state",      64'(dbg_state), 64'(S_IDLE));
    tick(3);
    check("halt_no_load_busy", 64'(busy), 64'd0);
    check("halt_s_ready",      64'(s_ready), 64'd0);
    check("halt_checksum_hold", 64'(checksum), 64'h0001_009D);

    // throttled stream of 3 words
    cur_prog[0] = 32'h1111_1111;
    cur_prog[1] = 32'h2222_2222;
    cur_prog[2] = 32'h8000_0001;
    do_start(10'd3);
    stream(3, 1'b1, 1'b1);
    wait_run(6, "throttle_run_latency");
    check("throttle_checksum", 64'(checksum), 64'h8000_0001);
    do_halt();

    // corrupted readback of word 2
    load_basic_prog();
    corrupt = 1'b1;
    do_start(10'd4);
    stream(4, 1'b0, 1'b1);
    n = 0; en_seen = 1'b0;
    while (!error && n < 100) begin
      @(posedge clk); #1; n++;
      if (cpu_enable) en_seen = 1'b1;
    end
    check("corrupt_err_latency", 64'(n), 64'd6);
    check("corrupt_err_code",    64'(err_code), 64'(ERR_CSUM));
    check("corrupt_cpu_enable",  64'(en_seen), 64'd0);
    check("corrupt_checksum",    64'(checksum), 64'h0001_009D);
    corrupt = 1'b0;
    tick(2);
    check("corrupt_sticky",      64'(error), 64'd1);
    check("corrupt_no_enable",   64'(cpu_enable), 64'd0);

    // legal start out of ERR clears the error
    cur_prog[0] = 32'hDEAD_BEEF;
    do_start(10'd1);
    check("recover_error",    64'(error), 64'd0);
    check("recover_err_code", 64'(err_code), 64'd0);
    check("recover_busy",     64'(busy), 64'd1);
    stream(1, 1'b0, 1'b1);
    wait_run(4, "len1_run_latency");
    check("len1_checksum", 64'(checksum), 64'hDEAD_BEEF);
    do_halt();

    // illegal lengths
    do_start(10'd513);
    check("len513_error",    64'(error), 64'd1);
    check("len513_err_code", 64'(err_code), 64'(ERR_LEN));
    check("len513_s_ready",  64'(s_ready), 64'd0);
    tick(2);
    do_start(10'd0);
    check("len0_error",    64'(error), 64'd1);
    check("len0_err_code", 64'(err_code), 64'(ERR_LEN));
    check("len0_s_ready",  64'(s_ready), 64'd0);
    check("len0_busy",     64'(busy), 64'd0);

    // reset in the middle of a load
    load_basic_prog();
    do_start(10'd4);
    check("midrst_start_error", 64'(error), 64'd0);
    stream(2, 1'b0, 1'b0);
    @(negedge clk); #1;
    arst_n = 1'b0;
    #1;
    check("midrst_wen",      64'(wen_ext), 64'd0);
    check("midrst_addr",     addr_ext, 64'd0);
    check("midrst_wdata",    64'(wdata_ext), 64'd0);
    check("midrst_checksum", 64'(checksum), 64'd0);
    check("midrst_busy",     64'(busy), 64'd0);
    check("midrst_s_ready",  64'(s_ready), 64'd0);
    check("midrst_state",    64'(dbg_state), 64'(S_IDLE));
    @(posedge clk); #1;
    arst_n = 1'b1;
    tick(1);
    do_start(10'd4);
    check("reload_checksum_seed", 64'(checksum), 64'd0);
    stream(4, 1'b0, 1'b1);
    wait_run(7, "reload_run_latency");
    check("reload_checksum", 64'(checksum), 64'h0001_009D);
    do_halt();

    tick(3);
    check("final_write_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_read_queue_empty",  64'(exp_rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
